// File: rtl/display_scanout.sv
// Raster scan-out engine: h/v timing, linear frame-buffer addressing,
// and delay-matched pixel/strobe output stream.
module display_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 64,
  parameter int H_BP       = 80,
  parameter int V_ACTIVE   = 400,
  parameter int V_FP       = 3,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 13,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fb_ready,
  output logic [17:0] fb_rd_addr,
  input  logic [3:0]  fb_rd_data,
  output logic [3:0]  pix_data,
  output logic        pix_de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam int NS = RD_LATENCY + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [17:0]        addr_q, addr_d;
  logic [17:0]        rd_addr_q, rd_addr_d;
  logic [NS-1:0][3:0] stg_q, stg_d;
  logic [3:0]         pix_q, pix_d;
  logic               de_q, de_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               fs_q, fs_d;
  logic               und_q, und_d;

  logic run, drop, active, hs_raw, vs_raw, first;
  logic h_wrap, v_wrap;

  always_comb begin
    run    = state_q == S_RUN;
    drop   = run && !fb_ready;
    active = run && int'(h_q) < H_ACTIVE
                 && int'(v_q) < V_ACTIVE;
    hs_raw = run && int'(h_q) >= HS_BEG
                 && int'(h_q) < HS_END;
    vs_raw = run && int'(v_q) >= VS_BEG
                 && int'(v_q) < VS_END;
    first  = run && h_q == '0 && v_q == '0;
    h_wrap = int'(h_q) == H_TOTAL - 1;
    v_wrap = int'(v_q) == V_TOTAL - 1;
  end

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    und_d     = und_q;
    // stage layout {first, vs, hs, active}; last stage meets RAM data
    stg_d = {stg_q[NS-2:0],
             {first, vs_raw, hs_raw, active}};
    pix_d = stg_q[NS-1][0] ? fb_rd_data : 4'd0;
    de_d  = stg_q[NS-1][0];
    hs_d  = stg_q[NS-1][1];
    vs_d  = stg_q[NS-1][2];
    fs_d  = stg_q[NS-1][3];
    if (drop) begin
      state_d   = S_IDLE;
      h_d       = '0;
      v_d       = '0;
      addr_d    = '0;
      rd_addr_d = '0;
      und_d     = 1'b1;
      stg_d     = '0;
      pix_d     = 4'd0;
      de_d      = 1'b0;
      hs_d      = 1'b0;
      vs_d      = 1'b0;
      fs_d      = 1'b0;
    end else if (run) begin
      if (active) begin
        rd_addr_d = addr_q;
        addr_d    = addr_q + 18'd1;
      end
      if (h_wrap) begin
        h_d = '0;
        if (v_wrap) begin
          v_d    = '0;
          addr_d = '0;
          if (!en) state_d = S_IDLE;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end else begin
      rd_addr_d = '0;
      if (en && fb_ready) state_d = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      stg_q     <= '0;
      pix_q     <= 4'd0;
      de_q      <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      fs_q      <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      stg_q     <= stg_d;
      pix_q     <= pix_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      fs_q      <= fs_d;
      und_q     <= und_d;
    end
  end

  assign fb_rd_addr  = rd_addr_q;
  assign pix_data    = pix_q;
  assign pix_de      = de_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign underrun    = und_q;

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: raster-position reference model,
// two instances (read latency 1 and 3) checked every cycle.
module tb_display_scanout;

  localparam int HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic fb_ready = 1'b0;

  logic [17:0] addr_a, addr_b;
  logic [3:0]  data_a, data_b, pix_a, pix_b;
  logic de_a, de_b, hs_a, hs_b, vs_a, vs_b;
  logic fs_a, fs_b, ur_a, ur_b;

  always #5 clk = ~clk;

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LATENCY(1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_ready(fb_ready),
    .fb_rd_addr(addr_a), .fb_rd_data(data_a),
    .pix_data(pix_a), .pix_de(de_a), .hsync(hs_a),
    .vsync(vs_a), .frame_start(fs_a), .underrun(ur_a)
  );

  display_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .RD_LATENCY(3)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .fb_ready(fb_ready),
    .fb_rd_addr(addr_b), .fb_rd_data(data_b),
    .pix_data(pix_b), .pix_de(de_b), .hsync(hs_b),
    .vsync(vs_b), .frame_start(fs_b), .underrun(ur_b)
  );

  // RAM models: return addr[3:0] after the configured latency
  logic [3:0] ra = 4'd0;
  logic [3:0] rb0 = 4'd0, rb1 = 4'd0, rb2 = 4'd0;
  always @(posedge clk) begin
    ra  <= addr_a[3:0];
    rb0 <= addr_b[3:0];
    rb1 <= rb0;
    rb2 <= rb1;
  end
  assign data_a = ra;
  assign data_b = rb2;

  int total = 0;
  int bad = 0;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               n, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       fs;
    logic       vs;
    logic       hs;
    logic       de;
    logic [3:0] px;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  ev_t ea = '0;
  ev_t eb = '0;
  ev_t ev;
  int  m_pos = 0;
  int  m_addr = 0;
  bit  m_run = 1'b0;
  bit  m_und = 1'b0;
  int  mh, mv;

  // Reference: raster position index -> expected outputs, delayed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_und = 1'b0;
      m_pos = 0; m_addr = 0;
      qa.delete(); qb.delete();
      ea = '0; eb = '0;
    end else begin
      ev = '0;
      if (m_run && !fb_ready) begin
        m_run = 1'b0; m_und = 1'b1;
        m_pos = 0; m_addr = 0;
        foreach (qa[i]) qa[i] = '0;
        foreach (qb[i]) qb[i] = '0;
      end else if (m_run) begin
        mh = m_pos % HT;
        mv = m_pos / HT;
        ev.de = (mh < HA) && (mv < VA);
        ev.hs = (mh >= HA + HFP) && (mh < HA + HFP + HS);
        ev.vs = (mv >= VA + VFP) && (mv < VA + VFP + VS);
        ev.fs = (m_pos == 0);
        if (ev.de) begin
          m_addr = mv * HA + mh;
          ev.px = 4'(m_addr % 16);
        end
        m_pos = (m_pos + 1) % FT;
        if (m_pos == 0 && !en) m_run = 1'b0;
      end else begin
        m_addr = 0;
        if (en && fb_ready) m_run = 1'b1;
      end
      qa.push_back(ev);
      qb.push_back(ev);
      ea = (qa.size() > 2) ? qa.pop_front() : '0;
      eb = (qb.size() > 4) ? qb.pop_front() : '0;
    end
  end

  always @(negedge clk) begin
    chk("de_a", int'(de_a), int'(ea.de));
    chk("pix_a", int'(pix_a), int'(ea.px));
    chk("hs_a", int'(hs_a), int'(ea.hs));
    chk("vs_a", int'(vs_a), int'(ea.vs));
    chk("fs_a", int'(fs_a), int'(ea.fs));
    chk("de_b", int'(de_b), int'(eb.de));
    chk("pix_b", int'(pix_b), int'(eb.px));
    chk("hs_b", int'(hs_b), int'(eb.hs));
    chk("vs_b", int'(vs_b), int'(eb.vs));
    chk("fs_b", int'(fs_b), int'(eb.fs));
    chk("addr_a", int'(addr_a), m_addr);
    chk("addr_b", int'(addr_b), m_addr);
    chk("ur_a", int'(ur_a), int'(m_und));
    chk("ur_b", int'(ur_b), int'(m_und));
  end

  task automatic wait_fs(input string n);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fs_a) break;
    end
    chk(n, int'(fs_a), 1);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_de"}, int'(de_a | de_b), 0);
    chk({n, "_pix"}, int'(pix_a | pix_b), 0);
    chk({n, "_hs"}, int'(hs_a | hs_b), 0);
    chk({n, "_vs"}, int'(vs_a | vs_b), 0);
    chk({n, "_fs"}, int'(fs_a | fs_b), 0);
    chk({n, "_addr"}, int'(addr_a | addr_b), 0);
  endtask

  initial begin
    int nde, nhs, nvs, nfs, hs_first, amax;
    fb_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    chk("reset_ur", int'(ur_a | ur_b), 0);
    rst_n = 1'b1;
    en = 1'b1;

    // first frame: hand-counted timing
    wait_fs("fs_first");
    chk("px0_de", int'(de_a), 1);
    chk("px0_data", int'(pix_a), 0);
    chk("px0_addr", int'(addr_a), 2);
    nde = 1; nhs = 0; nvs = 0; nfs = 0;
    hs_first = -1; amax = int'(addr_a);
    for (int k = 1; k < FT; k++) begin
      @(negedge clk);
      nde += int'(de_a);
      nhs += int'(hs_a);
      nvs += int'(vs_a);
      nfs += int'(fs_a);
      if (hs_a && hs_first < 0) hs_first = k;
      if (int'(addr_a) > amax) amax = int'(addr_a);
      if (k == 2) chk("fs_b_lag", int'(fs_b), 1);
    end
    chk("de_count", nde, 32);
    chk("hs_count", nhs, 14);
    chk("vs_count", nvs, 14);
    chk("fs_extra", nfs, 0);
    chk("hs_first", hs_first, 10);
    chk("addr_max", amax, 31);
    @(negedge clk);
    chk("fs_period", int'(fs_a), 1);

    // drop en mid-frame: frame completes, then idle
    en = 1'b0;
    nde = 0; amax = 0;
    for (int k = 0; k < FT + 20; k++) begin
      @(negedge clk);
      nde += int'(de_a);
      if (int'(addr_a) > amax) amax = int'(addr_a);
    end
    chk("en_drop_de", nde, 31);
    chk("en_drop_amax", amax, 31);
    chk_zero("idle");
    en = 1'b1;
    wait_fs("fs_restart");
    chk("restart_addr", int'(addr_a), 2);

    // fb_ready drop at pixel (3,2)
    for (int k = 0; k < 300; k++) begin
      if (m_run && m_pos == 31) break;
      @(negedge clk);
    end
    chk("reach_px32", m_pos, 31);
    fb_ready = 1'b0;
    @(negedge clk);
    chk("ur_set_a", int'(ur_a), 1);
    chk("ur_set_b", int'(ur_b), 1);
    chk("drop_de", int'(de_a | de_b), 0);
    fb_ready = 1'b1;
    wait_fs("fs_after_ur");
    chk("ur_addr", int'(addr_a), 2);
    chk("ur_sticky", int'(ur_a), 1);

    // randomized en / fb_ready activity
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) en = ~en;
      fb_ready = ($urandom_range(0, 69) != 0);
    end
    en = 1'b1;
    fb_ready = 1'b1;

    // asynchronous reset mid-line
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (m_run && (m_pos % HT) == 4 && m_pos < HT * VA) break;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async");
    chk("async_ur", int'(ur_a | ur_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs("fs_after_rst");
    chk("rst_addr", int'(addr_a), 2);
    repeat (FT + 10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
